// File: rtl/game_state_sched.sv
// rtl/game_state_sched.sv - frame-synchronous start/game/end screen sequencer
module game_state_sched #(
    parameter int unsigned END_HOLD    = 60,
    parameter int unsigned END_TIMEOUT = 600,
    parameter int unsigned CNT_W       = 10
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       frame_end,
    input  logic       start_req,
    input  logic       over_req,
    output logic [1:0] state,
    output logic       game_en,
    output logic       game_clr
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_GAME  = 2'd1;
    localparam logic [1:0] S_END   = 2'd2;

    // Frame counts compared against end_cnt; the timeout test uses the
    // count before increment, hence END_TIMEOUT - 1.
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(END_HOLD);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(END_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             pend_start_q, pend_start_d;
    logic             pend_over_q, pend_over_d;
    logic [CNT_W-1:0] end_cnt_q, end_cnt_d;
    logic             game_en_q, game_en_d;
    logic             game_clr_q, game_clr_d;

    logic eff_start;
    logic eff_over;
    logic hold_met;

    // A request arriving on the boundary cycle itself is honoured there.
    assign eff_start = pend_start_q | start_req;
    assign eff_over  = pend_over_q | over_req;
    assign hold_met  = (end_cnt_q >= HOLD_C);

    // State register: screen code, latched requests, end counter and outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_START;
            pend_start_q <= 1'b0;
            pend_over_q  <= 1'b0;
            end_cnt_q    <= '0;
            game_en_q    <= 1'b0;
            game_clr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_start_q <= pend_start_d;
            pend_over_q  <= pend_over_d;
            end_cnt_q    <= end_cnt_d;
            game_en_q    <= game_en_d;
            game_clr_q   <= game_clr_d;
        end
    end

    // Next-state: latch requests mid-frame, commit screen changes only on frame_end
    always_comb begin
        state_d      = state_q;
        pend_start_d = pend_start_q;
        pend_over_d  = pend_over_q;
        end_cnt_d    = end_cnt_q;
        case (state_q)
            S_START: begin
                if (frame_end && eff_start) begin
                    state_d      = S_GAME;
                    pend_start_d = 1'b0;
                    pend_over_d  = 1'b0;
                end else if (start_req) begin
                    pend_start_d = 1'b1;
                end
            end
            S_GAME: begin
                // start_req is deliberately not latched here, so over wins a tie
                if (frame_end && eff_over) begin
                    state_d      = S_END;
                    pend_start_d = 1'b0;
                    pend_over_d  = 1'b0;
                    end_cnt_d    = '0;
                end else if (over_req) begin
                    pend_over_d = 1'b1;
                end
            end
            S_END: begin
                if (frame_end) begin
                    if (eff_start && hold_met) begin
                        state_d      = S_GAME;
                        pend_start_d = 1'b0;
                        pend_over_d  = 1'b0;
                    end else if (end_cnt_q >= LAST_C) begin
                        state_d      = S_START;
                        pend_start_d = 1'b0;
                        pend_over_d  = 1'b0;
                        end_cnt_d    = '0;
                    end else begin
                        end_cnt_d = end_cnt_q + CNT_W'(1);
                    end
                end else if (start_req && hold_met) begin
                    // Restart presses during the hold window are dropped, not deferred
                    pend_start_d = 1'b1;
                end
            end
            default: begin
                state_d      = S_START;
                pend_start_d = 1'b0;
                pend_over_d  = 1'b0;
                end_cnt_d    = '0;
            end
        endcase
    end

    // Outputs: derived from the next state so they register alongside state_q
    always_comb begin
        game_en_d  = (state_d == S_GAME);
        game_clr_d = (state_d == S_GAME) && (state_q != S_GAME);
    end

    assign state    = state_q;
    assign game_en  = game_en_q;
    assign game_clr = game_clr_q;

endmodule

// File: tb/tb_game_state_sched.sv
// tb/tb_game_state_sched.sv - directed bench with behavioural screen model
module tb_game_state_sched;

    localparam int HOLD    = 2;
    localparam int TIMEOUT = 5;
    localparam int FRAME   = 20;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       frame_end = 1'b0;
    logic       start_req = 1'b0;
    logic       over_req = 1'b0;
    logic [1:0] state;
    logic       game_en;
    logic       game_clr;

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    game_state_sched #(
        .END_HOLD    (HOLD),
        .END_TIMEOUT (TIMEOUT),
        .CNT_W       (10)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .frame_end (frame_end),
        .start_req (start_req),
        .over_req  (over_req),
        .state     (state),
        .game_en   (game_en),
        .game_clr  (game_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: screen name, latched requests and frames spent on the end screen
    int  m_scr = 0;
    bit  m_ps = 0, m_po = 0, m_clr = 0, m_valid = 0;
    int  m_frames = 0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_scr = 0; m_ps = 0; m_po = 0; m_frames = 0; m_clr = 0; m_valid = 1;
        end else begin
            int prev;
            prev  = m_scr;
            m_clr = 0;
            if (m_scr == 0) begin
                if (frame_end && (m_ps || start_req)) m_scr = 1;
                else if (start_req) m_ps = 1;
            end else if (m_scr == 1) begin
                if (frame_end && (m_po || over_req)) begin
                    m_scr = 2; m_frames = 0;
                end else if (over_req) m_po = 1;
            end else begin
                if (frame_end) begin
                    if ((m_ps || start_req) && m_frames >= HOLD) m_scr = 1;
                    else if (m_frames + 1 >= TIMEOUT) m_scr = 0;
                    else m_frames = m_frames + 1;
                end else if (start_req && m_frames >= HOLD) m_ps = 1;
            end
            if (m_scr != prev) begin
                m_ps = 0; m_po = 0;
                if (m_scr == 1) m_clr = 1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            chk("model_state", int'(state), m_scr);
            chk("model_game_en", int'(game_en), int'(m_scr == 1));
            chk("model_game_clr", int'(game_clr), int'(m_clr));
        end
    end

    task automatic tick(input bit sr, input bit orq, input bit rst);
        sys_rst   = rst;
        frame_end = (phase == FRAME - 1);
        start_req = sr;
        over_req  = orq;
        @(posedge sys_clk);
        #1;
        phase = (phase + 1) % FRAME;
    endtask

    // Run until the frame phase reaches stop_ph; pulses fire at the given phases (-1 = none)
    task automatic run_until(input int sr_ph, input int or_ph, input int rst_ph, input int stop_ph);
        do begin
            tick(phase == sr_ph, phase == or_ph, phase == rst_ph);
        end while (phase != stop_ph);
        sys_rst = 1'b0; frame_end = 1'b0; start_req = 1'b0; over_req = 1'b0;
    endtask

    task automatic frame(input int sr_ph, input int or_ph);
        run_until(sr_ph, or_ph, -1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        phase   = 0;
        chk("reset_state", int'(state), 0);
        chk("reset_game_en", int'(game_en), 0);
        chk("reset_game_clr", int'(game_clr), 0);

        // start_req at phase 5 commits only at the frame_end
        run_until(5, -1, -1, 10);
        chk("start_wait_state", int'(state), 0);
        run_until(-1, -1, -1, 0);
        chk("enter_game_state", int'(state), 1);
        chk("enter_game_en", int'(game_en), 1);
        chk("enter_game_clr", int'(game_clr), 1);
        tick(0, 0, 0);
        chk("clr_one_cycle", int'(game_clr), 0);

        // over and start together in GAME: over wins, no clear pulse
        frame(7, 7);
        chk("over_wins_state", int'(state), 2);
        chk("over_wins_clr", int'(game_clr), 0);
        chk("end_game_en", int'(game_en), 0);

        // END hold: a start after one frame is dropped
        frame(-1, -1);
        frame(3, -1);
        chk("hold_drop_a", int'(state), 2);
        frame(-1, -1);
        chk("hold_drop_b", int'(state), 2);
        frame(4, -1);
        chk("restart_state", int'(state), 1);
        chk("restart_clr", int'(game_clr), 1);

        // start ignored in GAME, then over -> END and timeout back to START
        frame(5, -1);
        chk("game_ignores_start", int'(state), 1);
        frame(-1, 10);
        chk("end_again", int'(state), 2);
        repeat (4) frame(-1, -1);
        chk("before_timeout", int'(state), 2);
        frame(-1, -1);
        chk("timeout_state", int'(state), 0);

        // start coincident with frame_end in START
        frame(19, -1);
        chk("same_cycle_start", int'(state), 1);
        chk("same_cycle_clr", int'(game_clr), 1);

        // reset mid-frame with pend_over set
        run_until(-1, 3, 8, 9);
        chk("midreset_state", int'(state), 0);
        chk("midreset_game_en", int'(game_en), 0);
        run_until(-1, -1, -1, 0);
        chk("post_reset_frame", int'(state), 0);
        frame(-1, -1);
        chk("post_reset_frame2", int'(state), 0);

        @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
